// File: rtl/ultrasonic_responder.sv
// Ultrasonic range-sensor responder.
// Emulates the target side of a Trig/Echo distance sensor. A Trig pulse of
// sufficient width starts a measurement. After a fixed burst delay the module
// returns an Echo pulse whose width encodes the captured distance, then holds
// off for a dead time before it will accept another Trig.
module ultrasonic_responder #(
    parameter int unsigned CLK_PER_US  = 50,
    parameter int unsigned MIN_TRIG_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned US_PER_CM   = 58,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned HOLDOFF_US  = 10000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] dist_i,
    input  logic        trig_i,
    output logic        echo_o,
    output logic        busy_o,
    output logic        trig_short_o
);

    localparam logic [31:0] MIN_CYC     = 32'(MIN_TRIG_US * CLK_PER_US);
    localparam logic [31:0] BURST_LAST  = 32'(BURST_US * CLK_PER_US - 1);
    localparam logic [31:0] HOLD_LAST   = 32'(HOLDOFF_US * CLK_PER_US - 1);
    localparam logic [31:0] CYC_PER_CM  = 32'(US_PER_CM * CLK_PER_US);
    localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT_US * CLK_PER_US);
    localparam logic [15:0] MAX_DIST    = 16'(MAX_CM);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG_HI = 3'd1;
    localparam logic [2:0] S_BURST   = 3'd2;
    localparam logic [2:0] S_ECHO    = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] dist_q, dist_d;
    logic        echo_q, echo_d;
    logic        busy_q, busy_d;
    logic        short_q, short_d;
    logic        sync1_q, trig_s_q, trig_prev_q;

    logic        dist_in_range;
    logic [31:0] echo_width;
    logic [31:0] echo_last;

    // Two-flop synchronizer for the asynchronous Trig, plus a delayed copy for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            sync1_q     <= trig_i;
            trig_s_q    <= sync1_q;
            trig_prev_q <= trig_s_q;
        end
    end

    // Echo width in cycles from the captured distance; zero and too-far both map to the timeout width
    always_comb begin
        dist_in_range = (dist_q != 16'd0) && (dist_q <= MAX_DIST);
        echo_width    = dist_in_range ? (32'(dist_q) * CYC_PER_CM) : TIMEOUT_CYC;
        echo_last     = echo_width - 32'd1;
    end

    // Measurement FSM; one shared counter times Trig width, burst, echo and holdoff
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dist_d  = dist_q;
        echo_d  = echo_q;
        busy_d  = busy_q;
        short_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_s_q && !trig_prev_q) begin
                    state_d = S_TRIG_HI;
                    cnt_d   = 32'd0;
                end
            end
            S_TRIG_HI: begin
                if (trig_s_q) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else if (cnt_q >= MIN_CYC) begin
                    state_d = S_BURST;
                    dist_d  = dist_i;
                    busy_d  = 1'b1;
                    cnt_d   = 32'd0;
                end else begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                    cnt_d   = 32'd0;
                end
            end
            S_BURST: begin
                if (cnt_q == BURST_LAST) begin
                    state_d = S_ECHO;
                    echo_d  = 1'b1;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ECHO: begin
                if (cnt_q == echo_last) begin
                    state_d = S_HOLDOFF;
                    echo_d  = 1'b0;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                echo_d  = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // State and output registers; reset drops Echo and busy immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            dist_q  <= 16'd0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dist_q  <= dist_d;
            echo_q  <= echo_d;
            busy_q  <= busy_d;
            short_q <= short_d;
        end
    end

    assign echo_o       = echo_q;
    assign busy_o       = busy_q;
    assign trig_short_o = short_q;

endmodule

// File: tb/tb_ultrasonic_responder.sv
// Testbench for ultrasonic_responder.
// Drives Trig pulses and distances, and compares pulse timings against
// widths computed directly from the sensor's timing rules.
module tb_ultrasonic_responder;

    localparam int CLK_PER_US  = 2;
    localparam int MIN_TRIG_US = 10;
    localparam int BURST_US    = 5;
    localparam int US_PER_CM   = 58;
    localparam int MAX_CM      = 400;
    localparam int TIMEOUT_US  = 1000;
    localparam int HOLDOFF_US  = 50;

    localparam int MIN_CYC   = MIN_TRIG_US * CLK_PER_US;
    localparam int BURST_CYC = BURST_US * CLK_PER_US;
    localparam int HOLD_CYC  = HOLDOFF_US * CLK_PER_US;
    localparam int SYNC_LAT  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] distIn = 16'd0;
    logic        trigIn = 1'b0;
    logic        echoOut;
    logic        busyOut;
    logic        trigShortOut;

    int checks = 0;
    int errors = 0;
    int shortCount = 0;

    ultrasonic_responder #(
        .CLK_PER_US (CLK_PER_US),
        .MIN_TRIG_US(MIN_TRIG_US),
        .BURST_US   (BURST_US),
        .US_PER_CM  (US_PER_CM),
        .MAX_CM     (MAX_CM),
        .TIMEOUT_US (TIMEOUT_US),
        .HOLDOFF_US (HOLDOFF_US)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .dist_i      (distIn),
        .trig_i      (trigIn),
        .echo_o      (echoOut),
        .busy_o      (busyOut),
        .trig_short_o(trigShortOut)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Running tally of trig_short pulses seen by the bench
    always @(negedge clk) begin
        if (trigShortOut) shortCount++;
    end

    // Expected Echo width in cycles for a given captured distance
    function automatic int expWidth(input int d);
        if (d >= 1 && d <= MAX_CM) return d * US_PER_CM * CLK_PER_US;
        return TIMEOUT_US * CLK_PER_US;
    endfunction

    function automatic logic sigVal(input int which);
        case (which)
            0:       return echoOut;
            1:       return busyOut;
            default: return trigShortOut;
        endcase
    endfunction

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Set the distance and drive a Trig pulse of hiCycles clock periods
    task automatic applyStimulus(input int d, input int hiCycles);
        @(negedge clk);
        distIn = 16'(d);
        trigIn = 1'b1;
        repeat (hiCycles) @(negedge clk);
        trigIn = 1'b0;
    endtask

    // Count negedges until the selected output reaches val, bounded by limit
    task automatic waitSig(input int which, input logic val, input int limit, output int n);
        n = 0;
        while (sigVal(which) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Count cycles each output is high over a window
    task automatic watch(input int cycles, output int nEcho, output int nBusy, output int nShort);
        nEcho = 0; nBusy = 0; nShort = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (echoOut) nEcho++;
            if (busyOut) nBusy++;
            if (trigShortOut) nShort++;
        end
    endtask

    // One full measurement: pulse, then check either the echo timing or the short rejection
    task automatic runMeasurement(input string tag, input int d, input int hi, input int newDist);
        int n, w, s0, ne, nb, ns;
        s0 = shortCount;
        applyStimulus(d, hi);
        if (hi > MIN_CYC) begin
            waitSig(1, 1'b1, 20, n);
            checkOutput({tag, "_busy_rise"}, n, SYNC_LAT);
            distIn = 16'(newDist);
            waitSig(0, 1'b1, BURST_CYC + 20, n);
            checkOutput({tag, "_echo_rise"}, n, BURST_CYC);
            w = expWidth(d);
            waitSig(0, 1'b0, w + 20, n);
            checkOutput({tag, "_echo_width"}, n, w);
            waitSig(1, 1'b0, HOLD_CYC + 20, n);
            checkOutput({tag, "_busy_fall"}, n, HOLD_CYC);
            checkOutput({tag, "_no_short"}, shortCount - s0, 0);
        end else begin
            watch(15, ne, nb, ns);
            checkOutput({tag, "_short_pulse"}, ns, 1);
            checkOutput({tag, "_short_busy"}, nb, 0);
            checkOutput({tag, "_short_echo"}, ne, 0);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int n, w, s0, ne, nb, ns;
        int d, hi, nd;

        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("rst_echo", int'(echoOut), 0);
        checkOutput("rst_busy", int'(busyOut), 0);
        checkOutput("rst_short", int'(trigShortOut), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] basic, short, out-of-range runs");
        runMeasurement("d3", 3, 24, 3);
        runMeasurement("short12", 3, 12, 3);
        runMeasurement("d0", 0, 24, 0);
        runMeasurement("d401", 401, 24, 401);

        $display("[TB] Trig during ECHO and HOLDOFF ignored");
        s0 = shortCount;
        applyStimulus(10, 24);
        waitSig(1, 1'b1, 20, n);
        waitSig(0, 1'b1, BURST_CYC + 20, n);
        w = expWidth(10);
        applyStimulus(10, 24);
        waitSig(0, 1'b0, w + 20, n);
        checkOutput("ign_echo_width", n + 25, w);
        applyStimulus(10, 24);
        waitSig(1, 1'b0, HOLD_CYC + 20, n);
        checkOutput("ign_busy_fall", n + 25, HOLD_CYC);
        watch(40, ne, nb, ns);
        checkOutput("ign_no_busy", nb, 0);
        checkOutput("ign_no_short", shortCount - s0, 0);

        $display("[TB] Trig held across return to IDLE");
        s0 = shortCount;
        applyStimulus(4, 24);
        waitSig(1, 1'b1, 20, n);
        waitSig(0, 1'b1, BURST_CYC + 20, n);
        waitSig(0, 1'b0, expWidth(4) + 20, n);
        trigIn = 1'b1;
        waitSig(1, 1'b0, HOLD_CYC + 20, n);
        watch(30, ne, nb, ns);
        trigIn = 1'b0;
        checkOutput("held_no_busy", nb, 0);
        watch(15, ne, nb, ns);
        checkOutput("held_no_busy2", nb + ne, 0);
        checkOutput("held_no_short", shortCount - s0, 0);
        runMeasurement("after_held", 6, 30, 6);

        $display("[TB] reset mid-Echo");
        applyStimulus(20, 24);
        waitSig(1, 1'b1, 20, n);
        waitSig(0, 1'b1, BURST_CYC + 20, n);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_echo", int'(echoOut), 0);
        checkOutput("midrst_busy", int'(busyOut), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        watch(30, ne, nb, ns);
        checkOutput("postrst_idle", ne + nb + ns, 0);
        runMeasurement("postrst", 7, 30, 2);

        $display("[TB] randomized runs");
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) d = $urandom_range(401, 65535);
            else d = $urandom_range(0, 20);
            if ($urandom_range(0, 3) == 0) hi = $urandom_range(2, 15);
            else hi = $urandom_range(24, 40);
            nd = $urandom_range(0, 65535);
            runMeasurement($sformatf("rnd%0d", i), d, hi, nd);
        end

        $display("[TB] max distance with dist change during burst");
        runMeasurement("d400", 400, 24, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ultrasonic_responder.md
ULTRASONIC_RESPONDER -- requirements
Module: ultrasonic_responder

Interface
REQ-001 Parameter CLK_PER_US, default 50, Clock cycles per microsecond.
REQ-002 Parameter MIN_TRIG_US, default 10, minimum accepted Trig high width in us.
REQ-003 Parameter BURST_US, default 200, delay from accepted Trig fall to Echo rise in us.
REQ-004 Parameter US_PER_CM, default 58, Echo width per centimetre in us.
REQ-005 Parameter MAX_CM, default 400, largest in-range distance.
REQ-006 Parameter TIMEOUT_US, default 38000, Echo width for out-of-range distance in us.
REQ-007 Parameter HOLDOFF_US, default 10000, dead time after Echo fall in us.
REQ-008 Clock  input  1  single system clock; all state on rising edge.
REQ-009 Reset  input  1  asynchronous, active-high.
REQ-010 dist  input  16  simulated target distance in cm, unsigned.
REQ-011 Trig  input  1  trigger from the ultrasonic controller, asynchronous to Clock.
REQ-012 Echo  output  1  echo pulse to the controller, registered.
REQ-013 busy  output  1  high from Trig acceptance until holdoff ends, registered.
REQ-014 trig_short  output  1  one-cycle pulse: Trig high rejected as too short, registered.

Function
REQ-015 Trig SHALL pass a 2-flop synchronizer; all Trig decisions use the synchronized signal trig_s.
REQ-016 FSM states SHALL be IDLE, TRIG_HI, BURST, ECHO, HOLDOFF; one shared down/up cycle counter of 32 bits.
REQ-017 IDLE: trig_s rising -> TRIG_HI, counter cleared to 0.
REQ-018 TRIG_HI: counter increments each cycle trig_s high, saturating at 2^32-1.
REQ-019 TRIG_HI, trig_s falls with count >= MIN_TRIG_US*CLK_PER_US -> BURST; dist captured that same cycle; busy goes high next cycle.
REQ-020 TRIG_HI, trig_s falls with count < threshold -> IDLE; trig_short high exactly one cycle.
REQ-021 BURST SHALL last exactly BURST_US*CLK_PER_US cycles; Echo rises on the edge leaving BURST.
REQ-022 ECHO width: W = dist_cap*US_PER_CM*CLK_PER_US cycles if 1 <= dist_cap <= MAX_CM, else TIMEOUT_US*CLK_PER_US cycles (dist 0 and dist > MAX_CM both out of range).
REQ-023 Width product SHALL be computed at full 32-bit precision; no truncation for dist up to MAX_CM.
REQ-024 Echo SHALL be high for exactly W cycles, then low; state -> HOLDOFF.
REQ-025 HOLDOFF SHALL last exactly HOLDOFF_US*CLK_PER_US cycles, then IDLE; busy falls on that edge.
REQ-026 Trig activity in BURST, ECHO, HOLDOFF SHALL be ignored; no new measurement, no trig_short.
REQ-027 Trig already high when IDLE is re-entered SHALL NOT start a measurement; a fresh rising edge of trig_s is required.
REQ-028 dist changes after capture SHALL NOT affect the current Echo.

Reset
REQ-029 Reset asserted SHALL immediately force IDLE, Echo=0, busy=0, trig_short=0, counter=0, synchronizer flops=0, captured dist=0.
REQ-030 Reset mid-Echo SHALL drop Echo asynchronously; after release, a new full Trig is needed.

Verification (CLK_PER_US=2, MIN_TRIG_US=10, BURST_US=5, US_PER_CM=58, MAX_CM=400, TIMEOUT_US=1000, HOLDOFF_US=50)
REQ-031 dist=3, Trig high 24 cycles -> Echo rises 10 cycles after trig_s fall, high exactly 348 cycles, busy falls 100 cycles after Echo fall.
REQ-032 Trig high 12 cycles -> trig_short one cycle, Echo stays 0, busy stays 0.
REQ-033 dist=0 and dist=401 runs -> Echo high exactly 2000 cycles each.
REQ-034 Second Trig pulse during ECHO and during HOLDOFF -> ignored, Echo width unchanged, no trig_short.
REQ-035 Reset pulse mid-ECHO -> Echo=0 and busy=0 same time step; next valid Trig yields normal response.
REQ-036 dist=400 -> Echo high exactly 46400 cycles; dist changed to 5 during BURST -> width unchanged.
